decoder4_route_ctrl: RTL and testbench
======================================

// Module: decoder4_route_ctrl
// PURPOSE
//  Clocked route controller for the 2-way decoder4 datapath (9-bit flit, 1-bit select).
//  - Locks a route per packet from the head flit.
//  - Issues one select bit per flit, alongside the flit, through a 1-entry output register.
//  - Gates forwarding with per-output credit counters so neither Out0 nor Out1 overruns.
// PARAMETERS
//  W          9   flit width; bit W-1 = tail flag
//  ROUTE_BIT  0   head-flit bit selecting output (0 -> Out0, 1 -> Out1)
//  CREDITS    4   downstream buffer depth per output; credit counter reset value
//  CW         3   credit counter width, >= clog2(CREDITS+1)
// PORTS
//  CLK         in   1   clock, rising edge
//  _RESET      in   1   asynchronous active-low reset
//  in_flit     in   W   inbound flit
//  in_valid    in   1   inbound flit valid
//  in_ready    out  1   inbound flit accepted when in_valid & in_ready
//  dec_flit    out  W   flit to decoder
//  dec_sel     out  1   select bit to decoder, paired with dec_flit
//  dec_valid   out  1   output register holds a flit
//  dec_ready   in   1   decoder takes flit+sel when dec_valid & dec_ready
//  cr_ret      in   2   one-cycle credit-return pulse per output [0]=Out0 [1]=Out1
//  busy        out  1   packet in flight (state BODY) or dec_valid
//  credit_err  out  1   sticky: credit returned while counter already == CREDITS
// BEHAVIOUR
//  Reset (async assert, sync use after deassert):
//   - state=IDLE, route=0, dec_valid=0, dec_flit=0, dec_sel=0.
//   - cred[0]=cred[1]=CREDITS, credit_err=0.
//   - Reset mid-packet discards the packet and any flit held in the output register.
//  FSM:
//   - IDLE: the next accepted flit is a head. route_nxt=in_flit[ROUTE_BIT].
//     If the tail bit is 0 -> BODY with the route latched; tail=1 (single-flit packet) -> stay IDLE.
//   - BODY: accepted flits use the latched route; ROUTE_BIT is ignored.
//     An accepted tail flit -> IDLE.
//  eff_route = (state==IDLE) ? in_flit[ROUTE_BIT] : route.
//  in_ready  = (!dec_valid | dec_ready) & (cred[eff_route] != 0). Combinational, no dependency on in_valid.
//  Accept:
//   - dec_flit<=in_flit, dec_sel<=eff_route, dec_valid<=1. Latency in->dec = 1 cycle.
//   - Full throughput (1 flit/cycle) when dec_ready=1 and credits are available.
//  Drain without accept: dec_valid<=0. dec_flit and dec_sel hold their last value.
//  dec_flit/dec_sel stay stable while dec_valid & !dec_ready.
//  Credits, per output p:
//   - Decrement on accept routed to p; increment on cr_ret[p].
//   - Both in the same cycle -> unchanged.
//   - cr_ret[p] with cred[p]==CREDITS and no same-cycle decrement -> counter holds, credit_err<=1.
//   - cred[p]==0 stalls only flits routed to p.
//  Credit returned in cycle t is usable for acceptance in cycle t+1; no combinational cr_ret->in_ready path.
//  Route decision is per packet. A stall on one output blocks the inbound stream (no bypass, in-order).
// CONFIGURATION
//  DECODER4_ROUTE_STATS_EN
//   - Defined: adds outputs stat_flits0/stat_flits1 [15:0] and stat_pkts [15:0].
//     - stat_flits<p>: flits accepted toward output p.
//     - stat_pkts: tail flits accepted.
//     - Each counter saturates at 16'hFFFF and resets to 0 on _RESET.
//   - Undefined: those ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1 Reset, then 3-flit packet (head ROUTE_BIT=1, body, tail), dec_ready=1
//    -> dec_sel=1,1,1 one cycle after each accept; busy high until the cycle after the tail drains; cred[1]=1.
//  2 Single-flit packet (tail=1, ROUTE_BIT=0), then head with ROUTE_BIT=1
//    -> state stays IDLE; dec_sel=0 then 1.
//  3 CREDITS=4, no cr_ret, 6-flit packet to Out0
//    -> 4 accepted, then in_ready=0.
//    -> cr_ret[0] pulse at cycle t -> 5th flit accepted at t+1.
//  4 dec_ready=0 for 5 cycles with a flit held
//    -> dec_flit/dec_sel stable, in_ready=0.
//    -> dec_ready=1 -> back-to-back acceptance resumes.
//  5 cr_ret[0] pulse with cred[0]=CREDITS
//    -> credit_err=1 and stays 1; cred[0] stays 4.
//    -> Simultaneous accept + cr_ret on same port -> count unchanged.
//  6 _RESET low mid-packet (BODY, dec_valid=1)
//    -> immediate dec_valid=0, state IDLE, creds=CREDITS.
//    -> With DECODER4_ROUTE_STATS_EN defined: stat_* counters = 0.

Source files
------------

// File: rtl/decoder4_route_ctrl.sv
// decoder4_route_ctrl: per-packet route lock, 1-entry output register and
// per-output credit gating for the 2-way decoder4 datapath.
//
// Ports:
//   CLK, _RESET          clock (rising edge), async active-low reset
//   in_flit/valid/ready  inbound flit handshake
//   dec_flit/sel/valid   registered flit + select bit toward the decoder
//   dec_ready            decoder accepts the registered flit
//   cr_ret[1:0]          credit-return pulses, [0]=Out0 [1]=Out1
//   busy                 packet in flight or output register occupied
//   credit_err           sticky credit-overflow flag
//
// Optional build macro: DECODER4_ROUTE_STATS_EN adds saturating
// stat_flits0, stat_flits1 and stat_pkts counters.

module decoder4_route_ctrl #(
    parameter int W         = 9,
    parameter int ROUTE_BIT = 0,
    parameter int CREDITS   = 4,
    parameter int CW        = 3
) (
    input  logic         CLK,
    input  logic         _RESET,
    input  logic [W-1:0] in_flit,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] dec_flit,
    output logic         dec_sel,
    output logic         dec_valid,
    input  logic         dec_ready,
    input  logic [1:0]   cr_ret,
    output logic         busy,
    output logic         credit_err
`ifdef DECODER4_ROUTE_STATS_EN
    ,
    output logic [15:0]  stat_flits0,
    output logic [15:0]  stat_flits1,
    output logic [15:0]  stat_pkts
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } state_t;

    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
    localparam logic [CW-1:0] CRED_ONE = CW'(1);

    state_t         state_q, state_d;
    logic           route_q, route_d;
    logic [W-1:0]   flit_q, flit_d;
    logic           sel_q, sel_d;
    logic           valid_q, valid_d;
    logic [CW-1:0]  cred_q [2];
    logic [CW-1:0]  cred_d [2];
    logic           err_q, err_d;

    logic           eff_route;
    logic           out_free;
    logic           accept;
    logic           tail;
    logic [1:0]     take;

    // Head flits steer by their own route bit; body flits follow the lock.
    assign eff_route = (state_q == IDLE) ? in_flit[ROUTE_BIT] : route_q;
    assign out_free  = !valid_q || dec_ready;
    // Registered credits only, so a returned credit is usable next cycle.
    assign in_ready  = out_free && (cred_q[eff_route] != '0);
    assign accept    = in_valid && in_ready;
    assign tail      = in_flit[W-1];
    assign take[0]   = accept && !eff_route;
    assign take[1]   = accept && eff_route;

    assign dec_flit   = flit_q;
    assign dec_sel    = sel_q;
    assign dec_valid  = valid_q;
    assign busy       = (state_q == BODY) || valid_q;
    assign credit_err = err_q;

    // Packet FSM: route latched on a non-tail head, released on tail.
    always_comb begin
        state_d = state_q;
        route_d = route_q;
        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    if (!tail) begin
                        state_d = BODY;
                        route_d = in_flit[ROUTE_BIT];
                    end
                end
                BODY: begin
                    if (tail) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output register: load on accept, empty on drain, otherwise hold.
    always_comb begin
        flit_d  = flit_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        if (accept) begin
            flit_d  = in_flit;
            sel_d   = eff_route;
            valid_d = 1'b1;
        end else if (dec_ready) begin
            valid_d = 1'b0;
        end
    end

    // Credit counters. Simultaneous take and return cancel; a return into
    // a full counter is dropped and flagged.
    always_comb begin
        err_d     = err_q;
        cred_d[0] = cred_q[0];
        cred_d[1] = cred_q[1];
        for (int p = 0; p < 2; p++) begin
            if (take[p] && !cr_ret[p]) begin
                cred_d[p] = cred_q[p] - CRED_ONE;
            end else if (!take[p] && cr_ret[p]) begin
                if (cred_q[p] == CRED_MAX) begin
                    err_d = 1'b1;
                end else begin
                    cred_d[p] = cred_q[p] + CRED_ONE;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            state_q   <= IDLE;
            route_q   <= 1'b0;
            flit_q    <= '0;
            sel_q     <= 1'b0;
            valid_q   <= 1'b0;
            cred_q[0] <= CRED_MAX;
            cred_q[1] <= CRED_MAX;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            route_q   <= route_d;
            flit_q    <= flit_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            cred_q[0] <= cred_d[0];
            cred_q[1] <= cred_d[1];
            err_q     <= err_d;
        end
    end

`ifdef DECODER4_ROUTE_STATS_EN
    logic [15:0] sf0_q, sf0_d;
    logic [15:0] sf1_q, sf1_d;
    logic [15:0] spk_q, spk_d;

    // Saturating event counters.
    always_comb begin
        sf0_d = sf0_q;
        sf1_d = sf1_q;
        spk_d = spk_q;
        if (take[0] && (sf0_q != 16'hFFFF)) begin
            sf0_d = sf0_q + 16'd1;
        end
        if (take[1] && (sf1_q != 16'hFFFF)) begin
            sf1_d = sf1_q + 16'd1;
        end
        if (accept && tail && (spk_q != 16'hFFFF)) begin
            spk_d = spk_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            sf0_q <= '0;
            sf1_q <= '0;
            spk_q <= '0;
        end else begin
            sf0_q <= sf0_d;
            sf1_q <= sf1_d;
            spk_q <= spk_d;
        end
    end

    assign stat_flits0 = sf0_q;
    assign stat_flits1 = sf1_q;
    assign stat_pkts   = spk_q;
`endif

endmodule

// File: tb/tb_decoder4_route_ctrl.sv
// Directed self-checking bench for decoder4_route_ctrl.
// Inputs change and outputs are sampled 1-2 time units after rising edges.

module tb_decoder4_route_ctrl;

    logic       CLK = 1'b0;
    logic       _RESET;
    logic [8:0] in_flit;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] dec_flit;
    logic       dec_sel;
    logic       dec_valid;
    logic       dec_ready;
    logic [1:0] cr_ret;
    logic       busy;
    logic       credit_err;
`ifdef DECODER4_ROUTE_STATS_EN
    logic [15:0] stat_flits0;
    logic [15:0] stat_flits1;
    logic [15:0] stat_pkts;
`endif

    int checks = 0;
    int passes = 0;

    decoder4_route_ctrl dut (
        .CLK        (CLK),
        ._RESET     (_RESET),
        .in_flit    (in_flit),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dec_flit   (dec_flit),
        .dec_sel    (dec_sel),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .cr_ret     (cr_ret),
        .busy       (busy),
        .credit_err (credit_err)
`ifdef DECODER4_ROUTE_STATS_EN
        ,
        .stat_flits0(stat_flits0),
        .stat_flits1(stat_flits1),
        .stat_pkts  (stat_pkts)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        in_flit   = '0;
        in_valid  = 1'b0;
        dec_ready = 1'b1;
        cr_ret    = 2'b00;
        _RESET    = 1'b0;
        cyc();
        cyc();
        _RESET = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (dec_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", dec_valid); else passes++;
        checks++; if (dec_flit !== 9'h000) $display("FAIL rst_flit got %h exp 000", dec_flit); else passes++;
        checks++; if (dec_sel !== 1'b0) $display("FAIL rst_sel got %b exp 0", dec_sel); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else passes++;
        checks++; if (credit_err !== 1'b0) $display("FAIL rst_err got %b exp 0", credit_err); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", in_ready); else passes++;
`ifdef DECODER4_ROUTE_STATS_EN
        checks++; if (stat_pkts !== 16'd0) $display("FAIL rst_pkts got %0d exp 0", stat_pkts); else passes++;
`endif
    endtask

    task automatic test_packet3();
        do_reset();
        in_valid = 1'b1;
        in_flit  = 9'h0A3;
        cyc();
        checks++; if (dec_valid !== 1'b1) $display("FAIL p3_head_valid got %b exp 1", dec_valid); else passes++;
        checks++; if (dec_flit !== 9'h0A3) $display("FAIL p3_head_flit got %h exp 0a3", dec_flit); else passes++;
        checks++; if (dec_sel !== 1'b1) $display("FAIL p3_head_sel got %b exp 1", dec_sel); else passes++;
        in_flit = 9'h054;
        cyc();
        checks++; if (dec_flit !== 9'h054) $display("FAIL p3_body_flit got %h exp 054", dec_flit); else passes++;
        checks++; if (dec_sel !== 1'b1) $display("FAIL p3_body_sel got %b exp 1", dec_sel); else passes++;
        in_flit = 9'h1F0;
        cyc();
        checks++; if (dec_sel !== 1'b1) $display("FAIL p3_tail_sel got %b exp 1", dec_sel); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL p3_tail_busy got %b exp 1", busy); else passes++;
        in_valid = 1'b0;
        cyc();
        checks++; if (busy !== 1'b0) $display("FAIL p3_drain_busy got %b exp 0", busy); else passes++;
`ifdef DECODER4_ROUTE_STATS_EN
        checks++; if (stat_flits1 !== 16'd3) $display("FAIL p3_sf1 got %0d exp 3", stat_flits1); else passes++;
        checks++; if (stat_pkts !== 16'd1) $display("FAIL p3_pkts got %0d exp 1", stat_pkts); else passes++;
`endif
        // cred[1] is now 1: exactly one more Out1 flit fits
        in_valid = 1'b1;
        in_flit  = 9'h101;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL p3_cred1_last got %b exp 1", in_ready); else passes++;
        cyc();
        checks++; if (in_ready !== 1'b0) $display("FAIL p3_cred1_empty got %b exp 0", in_ready); else passes++;
        in_flit = 9'h100;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL p3_out0_free got %b exp 1", in_ready); else passes++;
        in_flit = 9'h101;
        cr_ret  = 2'b10;
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL p3_ret_same_cycle got %b exp 0", in_ready); else passes++;
        cyc();
        cr_ret = 2'b00;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL p3_ret_next_cycle got %b exp 1", in_ready); else passes++;
        in_valid = 1'b0;
    endtask

    task automatic test_single_flit();
        do_reset();
        in_valid = 1'b1;
        in_flit  = 9'h100;
        cyc();
        checks++; if (dec_sel !== 1'b0) $display("FAIL sf_sel0 got %b exp 0", dec_sel); else passes++;
        in_valid = 1'b0;
        cyc();
        checks++; if (busy !== 1'b0) $display("FAIL sf_idle_busy got %b exp 0", busy); else passes++;
        in_valid = 1'b1;
        in_flit  = 9'h003;
        cyc();
        checks++; if (dec_sel !== 1'b1) $display("FAIL sf_sel1 got %b exp 1", dec_sel); else passes++;
        in_valid = 1'b0;
        cyc();
        checks++; if (busy !== 1'b1) $display("FAIL sf_body_busy got %b exp 1", busy); else passes++;
        checks++; if (dec_valid !== 1'b0) $display("FAIL sf_drained got %b exp 0", dec_valid); else passes++;
    endtask

    task automatic test_credit_stall();
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_flit = (i == 0) ? 9'h010 : 9'(9'h020 + 9'(i) * 2 + 1);
            #1;
            checks++; if (in_ready !== 1'b1) $display("FAIL cs_ready%0d got %b exp 1", i, in_ready); else passes++;
            cyc();
        end
        in_flit = 9'h0F1;
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL cs_stall got %b exp 0", in_ready); else passes++;
        cyc();
        checks++; if (dec_valid !== 1'b0) $display("FAIL cs_drain_valid got %b exp 0", dec_valid); else passes++;
        checks++; if (dec_flit !== 9'h027) $display("FAIL cs_hold_flit got %h exp 027", dec_flit); else passes++;
        cr_ret = 2'b01;
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL cs_ret_t got %b exp 0", in_ready); else passes++;
        cyc();
        cr_ret = 2'b00;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL cs_ret_t1 got %b exp 1", in_ready); else passes++;
        cyc();
        checks++; if (dec_flit !== 9'h0F1) $display("FAIL cs_fifth_flit got %h exp 0f1", dec_flit); else passes++;
        checks++; if (dec_sel !== 1'b0) $display("FAIL cs_fifth_sel got %b exp 0", dec_sel); else passes++;
        checks++; if (in_ready !== 1'b0) $display("FAIL cs_restall got %b exp 0", in_ready); else passes++;
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid = 1'b1;
        in_flit  = 9'h0A0;
        cyc();
        dec_ready = 1'b0;
        in_flit   = 9'h0B1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) $display("FAIL bp_ready%0d got %b exp 0", i, in_ready); else passes++;
            checks++; if (dec_flit !== 9'h0A0) $display("FAIL bp_flit%0d got %h exp 0a0", i, dec_flit); else passes++;
            checks++; if (dec_valid !== 1'b1) $display("FAIL bp_valid%0d got %b exp 1", i, dec_valid); else passes++;
            cyc();
        end
        checks++; if (dec_sel !== 1'b0) $display("FAIL bp_sel got %b exp 0", dec_sel); else passes++;
        dec_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL bp_resume got %b exp 1", in_ready); else passes++;
        cyc();
        checks++; if (dec_flit !== 9'h0B1) $display("FAIL bp_b2b1 got %h exp 0b1", dec_flit); else passes++;
        in_flit = 9'h1C0;
        cyc();
        checks++; if (dec_flit !== 9'h1C0) $display("FAIL bp_b2b2 got %h exp 1c0", dec_flit); else passes++;
        checks++; if (dec_valid !== 1'b1) $display("FAIL bp_b2b_valid got %b exp 1", dec_valid); else passes++;
        in_valid = 1'b0;
    endtask

    task automatic test_credit_err();
        int acc;
        do_reset();
        cr_ret = 2'b01;
        cyc();
        cr_ret = 2'b00;
        checks++; if (credit_err !== 1'b1) $display("FAIL ce_set got %b exp 1", credit_err); else passes++;
        cyc();
        cyc();
        checks++; if (credit_err !== 1'b1) $display("FAIL ce_sticky got %b exp 1", credit_err); else passes++;
        acc = 0;
        in_valid = 1'b1;
        in_flit  = 9'h000;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (in_ready) acc++;
            cyc();
            in_flit = 9'h001;
        end
        checks++; if (acc !== 4) $display("FAIL ce_cred_full got %0d exp 4", acc); else passes++;
        do_reset();
        in_valid = 1'b1;
        in_flit  = 9'h000;
        cyc();
        in_flit = 9'h003;
        cr_ret  = 2'b01;
        cyc();
        cr_ret = 2'b00;
        checks++; if (dec_flit !== 9'h003) $display("FAIL ce_sim_acc got %h exp 003", dec_flit); else passes++;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (in_ready) acc++;
            cyc();
        end
        checks++; if (acc !== 3) $display("FAIL ce_sim_unchanged got %0d exp 3", acc); else passes++;
        checks++; if (credit_err !== 1'b0) $display("FAIL ce_sim_noerr got %b exp 0", credit_err); else passes++;
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midpkt();
        int acc;
        do_reset();
        in_valid = 1'b1;
        in_flit  = 9'h001;
        cyc();
        in_flit = 9'h002;
        cyc();
        in_valid = 1'b0;
        checks++; if (dec_valid !== 1'b1) $display("FAIL rm_pre_valid got %b exp 1", dec_valid); else passes++;
`ifdef DECODER4_ROUTE_STATS_EN
        checks++; if (stat_flits1 !== 16'd2) $display("FAIL rm_pre_sf1 got %0d exp 2", stat_flits1); else passes++;
`endif
        #2;
        _RESET = 1'b0;
        #1;
        checks++; if (dec_valid !== 1'b0) $display("FAIL rm_valid got %b exp 0", dec_valid); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL rm_busy got %b exp 0", busy); else passes++;
        checks++; if (dec_flit !== 9'h000) $display("FAIL rm_flit got %h exp 000", dec_flit); else passes++;
`ifdef DECODER4_ROUTE_STATS_EN
        checks++; if (stat_flits1 !== 16'd0) $display("FAIL rm_sf1 got %0d exp 0", stat_flits1); else passes++;
        checks++; if (stat_flits0 !== 16'd0) $display("FAIL rm_sf0 got %0d exp 0", stat_flits0); else passes++;
`endif
        cyc();
        _RESET = 1'b1;
        #1;
        acc = 0;
        in_valid = 1'b1;
        in_flit  = 9'h101;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (in_ready) acc++;
            cyc();
        end
        checks++; if (acc !== 4) $display("FAIL rm_creds got %0d exp 4", acc); else passes++;
        in_valid = 1'b0;
    endtask

    initial begin
        _RESET    = 1'b0;
        in_flit   = '0;
        in_valid  = 1'b0;
        dec_ready = 1'b1;
        cr_ret    = 2'b00;
        test_reset();
        test_packet3();
        test_single_flit();
        test_credit_stall();
        test_backpressure();
        test_credit_err();
        test_reset_midpkt();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
